instr_fetch_ctrl: RTL and testbench

//  Sequences the synchronous instruction memory (mem_instruction). Holds the fetch PC,

---
 rtl/instr_fetch_ctrl_pkg.sv | 27 ++
 rtl/instr_fetch_ctrl_fifo.sv | 81 ++++++++
 rtl/instr_fetch_ctrl.sv | 104 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_ctrl_pkg
// Purpose  : Shared widths, constants, the {pc, instr} fetch entry type and
//            a word-alignment helper for the instruction fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_ctrl_pkg;

    localparam int              c_INSTR_W      = 32;
    localparam int              c_ADDR_W       = 32;
    localparam logic [31:0]     c_PC_INC       = 32'd4;
    localparam logic [31:0]     c_RESET_VECTOR = 32'h0000_0000;

    // One buffered fetch: the byte address it was read from and the word itself.
    typedef struct packed {
        logic [c_ADDR_W-1:0]  pc;
        logic [c_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instruction memory is word addressed; byte-offset bits are discarded.
    function automatic logic [c_ADDR_W-1:0] word_align(input logic [c_ADDR_W-1:0] addr);
        return {addr[c_ADDR_W-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_ctrl_fifo
// Purpose  : DEPTH-entry synchronous FIFO of {pc, instr} fetch entries.
//            Flush has priority over push and pop.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_push/i_push_data- write one entry
//            i_pop             - remove head entry (ignored when empty)
//            i_flush           - discard all entries
//            o_head            - entry at the head (zero after reset)
//            o_count           - number of valid entries
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl_fifo
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  fetch_entry_t               i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_do_pop;
    logic                 w_do_push;

    // Pointers wrap explicitly so non power-of-two depths work.
    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_LAST) ? '0 : ptr + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_FULL) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_ctrl
// Purpose  : Instruction fetch sequencer for a 1-cycle synchronous instruction
//            memory. Issues one word address per cycle while buffer space is
//            guaranteed, buffers returned words and hands {pc, instr} to
//            decode over valid/ready. A redirect flushes buffered and
//            in-flight fetches and restarts at the new target.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            mem_address (out)    - registered word address to memory
//            mem_instruction (in) - read data, one cycle after mem_address
//            instr_valid/ready    - handshake toward decode
//            instr, instr_pc      - word and byte address at the buffer head
//            redirect_valid/pc    - taken branch/jump and its target
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_VECTOR,
    parameter int          DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [c_ADDR_W-1:0]  mem_address,
    input  logic [c_INSTR_W-1:0] mem_instruction,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [c_INSTR_W-1:0] instr,
    output logic [c_ADDR_W-1:0]  instr_pc,
    input  logic                 redirect_valid,
    input  logic [c_ADDR_W-1:0]  redirect_pc
);

    localparam int                  c_CNT_W     = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0]    c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);
    localparam logic [c_ADDR_W-1:0] c_START_PC  = word_align(RESET_PC);

    logic [c_ADDR_W-1:0] r_fetch_pc;
    logic [c_ADDR_W-1:0] r_req_pc;
    logic                r_inflight;

    logic [c_CNT_W-1:0]  w_count;
    logic [c_CNT_W:0]    w_occupancy;
    fetch_entry_t        w_head;
    fetch_entry_t        w_entry;
    logic                w_pop;
    logic                w_push;
    logic                w_issue;

    assign w_pop  = instr_valid && instr_ready;

    // A redirect cycle's response belongs to the abandoned path.
    assign w_push = r_inflight && !redirect_valid;

    // Entries that will exist once this cycle's pop and the outstanding
    // response settle; issuing only below DEPTH means the response of the
    // address issued now always finds a free slot.
    assign w_occupancy = {1'b0, w_count}
                       + {{c_CNT_W{1'b0}}, r_inflight}
                       - {{c_CNT_W{1'b0}}, w_pop};

    assign w_issue = !redirect_valid && (w_occupancy < c_DEPTH_EXT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= c_START_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= word_align(redirect_pc);
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + c_PC_INC;
            r_inflight <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    assign w_entry = '{pc: r_req_pc, instr: mem_instruction};

    instr_fetch_ctrl_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_entry),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // The address register is the memory request itself.
    assign mem_address = r_fetch_pc;
    assign instr_valid = (w_count != '0);
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_ctrl
// Purpose  : Self-checking bench for instr_fetch_ctrl: directed scenarios,
//            then randomized ready/redirect/reset traffic compared every
//            cycle against a queue-based reference model, plus an
//            in-order stream scoreboard on accepted instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

    localparam int          c_DEPTH  = 2;
    localparam logic [31:0] c_RST_PC = 32'h0000_0000;
    localparam logic [31:0] c_RST_PC2 = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst;
    logic [31:0] mem_address;
    logic [31:0] mem_instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] mem_address2;
    logic [31:0] mem_instruction2;
    logic        instr_valid2;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_ctrl #(
        .RESET_PC (c_RST_PC),
        .DEPTH    (c_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_instruction (mem_instruction),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    // Second instance exercises address wrap-around from a high reset PC.
    instr_fetch_ctrl #(
        .RESET_PC (c_RST_PC2),
        .DEPTH    (c_DEPTH)
    ) dut2 (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address2),
        .mem_instruction (mem_instruction2),
        .instr_valid     (instr_valid2),
        .instr_ready     (1'b1),
        .instr           (instr2),
        .instr_pc        (instr_pc2),
        .redirect_valid  (1'b0),
        .redirect_pc     (32'h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word at address A is {16'hC0DE, A[15:0]}, one-cycle read.
    always @(posedge clk) begin
        mem_instruction  <= {16'hC0DE, mem_address[15:0]};
        mem_instruction2 <= {16'hC0DE, mem_address2[15:0]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: queue of buffered PCs, one outstanding request,
    // and the next PC to fetch. State reflects the current cycle.
    // ------------------------------------------------------------------
    logic [31:0] m_q[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_fpc;
    bit          m_on = 1'b0;
    bit          m_pop;
    int          m_occ;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_pend = 1'b0;
            m_fpc  = c_RST_PC & ~32'd3;
            m_on   = 1'b1;
        end else if (m_on) begin
            m_pop = (m_q.size() != 0) && instr_ready;
            if (redirect_valid) begin
                m_q.delete();
                m_pend = 1'b0;
                m_fpc  = redirect_pc & ~32'd3;
            end else begin
                m_occ = m_q.size() + (m_pend ? 1 : 0) - (m_pop ? 1 : 0);
                if (m_pop) void'(m_q.pop_front());
                if (m_pend) m_q.push_back(m_pend_pc);
                if (m_occ < c_DEPTH) begin
                    m_pend    = 1'b1;
                    m_pend_pc = m_fpc;
                    m_fpc     = m_fpc + 32'd4;
                end else begin
                    m_pend = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison and accepted-stream scoreboard.
    // ------------------------------------------------------------------
    logic [31:0] sb_next;

    always @(negedge clk) begin
        if (m_on) begin
            check("instr_valid", {31'b0, instr_valid}, {31'b0, (m_q.size() != 0)});
            if (m_q.size() != 0) begin
                check("instr_pc", instr_pc, m_q[0]);
                check("instr", instr, {16'hC0DE, m_q[0][15:0]});
            end
            check("mem_address", mem_address, m_fpc);

            if (rst) begin
                sb_next = c_RST_PC & ~32'd3;
            end else begin
                if (instr_valid && instr_ready) begin
                    check("stream_order", instr_pc, sb_next);
                    sb_next = instr_pc + 32'd4;
                end
                if (redirect_valid) sb_next = redirect_pc & ~32'd3;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit got;
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        step();
        rst         = 1'b0;
        instr_ready = 1'b1;

        // Fetch latency and first words of both instances.
        step();
        check("first_cycle_empty", {31'b0, instr_valid}, 32'd0);
        step();
        check("lit_pc0", instr_pc, 32'h0000_0000);
        check("lit_instr0", instr, 32'hC0DE_0000);
        check("wrap_pc0", instr_pc2, 32'hFFFF_FFF8);
        check("wrap_instr0", instr2, 32'hC0DE_FFF8);
        step();
        check("lit_pc4", instr_pc, 32'h0000_0004);
        check("wrap_pc1", instr_pc2, 32'hFFFF_FFFC);

        // Stall decode for ten cycles.
        instr_ready = 1'b0;
        step();
        check("wrap_pc2", instr_pc2, 32'h0000_0000);
        check("wrap_valid2", {31'b0, instr_valid2}, 32'd1);
        repeat (9) step();
        check("held_valid", {31'b0, instr_valid}, 32'd1);
        check("held_pc", instr_pc, 32'h0000_0004);
        check("held_next_addr", mem_address, 32'h0000_000C);
        check("held_words", m_q.size(), 32'd2);

        // Release: consecutive words with no gap.
        instr_ready = 1'b1;
        step();
        check("release_pc8", instr_pc, 32'h0000_0008);
        step();
        check("release_pc12", instr_pc, 32'h0000_000C);
        check("release_valid", {31'b0, instr_valid}, 32'd1);
        step();
        check("release_pc16", instr_pc, 32'h0000_0010);

        // Mid-stream redirect to an unaligned target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        check("redir_gap1", {31'b0, instr_valid}, 32'd0);
        step();
        check("redir_gap2", {31'b0, instr_valid}, 32'd0);
        step();
        check("redir_valid", {31'b0, instr_valid}, 32'd1);
        check("redir_pc", instr_pc, 32'h0000_0100);
        check("redir_instr", instr, 32'hC0DE_0100);

        // Back-to-back redirects: the later target wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_pc    = 32'h0000_0080;
        step();
        redirect_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (instr_valid) begin
                got = 1'b1;
                check("b2b_first_pc", instr_pc, 32'h0000_0080);
            end else begin
                step();
            end
        end
        if (!got) check("b2b_timeout", 32'd0, 32'd1);

        // Randomized traffic with an explicit mid-stream reset.
        for (int i = 0; i < 3000; i++) begin
            rst            = (i == 1500) || ($urandom_range(0, 399) == 0);
            redirect_valid = !rst && ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            if ((i / 200) % 3 == 2) instr_ready = ($urandom_range(0, 3) == 0);
            else                    instr_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        rst            = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
